// File: rtl/intr_ctrl.sv
// intr_ctrl: interrupt controller and carry/zero flag-bank register file.
//
// Detects rising edges on irq lines, serves the lowest pending index when
// enabled, redirects the PC to a per-line vector for one ENTER cycle, saves
// the return address and holds the CPU in SERVICE mode until reti.
// Also holds the ALU carry/zero flags; with INTR_FLAG_BANK_EN defined a
// separate bank is used while servicing, otherwise one bank is shared.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   irq[N_IRQ]            external requests, rising-edge sensitive
//   ei, di, reti          decoded instruction strobes
//   pc_now[PC_WIDTH]      address of the instruction fetched this cycle
//   flag_we, alu_carry, alu_zero   flag write strobe and values
//   take                  PC mux selects vector, current instruction annulled
//   vector[PC_WIDTH]      VEC_BASE + 4*id of the served line
//   ret_pc[PC_WIDTH]      saved return address
//   irq_ack[N_IRQ]        one-hot acknowledge during ENTER
//   interruption          high in SERVICE
//   ie                    global interrupt enable
//   carry, zero           flags of the active bank
//
// Configuration macro: INTR_FLAG_BANK_EN (separate interrupt flag bank).

module intr_ctrl #(
    parameter int unsigned          PC_WIDTH = 10,
    parameter int unsigned          N_IRQ    = 4,
    parameter logic [PC_WIDTH-1:0]  VEC_BASE = 10'h3C0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_IRQ-1:0]    irq,
    input  logic                ei,
    input  logic                di,
    input  logic                reti,
    input  logic [PC_WIDTH-1:0] pc_now,
    input  logic                flag_we,
    input  logic                alu_carry,
    input  logic                alu_zero,
    output logic                take,
    output logic [PC_WIDTH-1:0] vector,
    output logic [PC_WIDTH-1:0] ret_pc,
    output logic [N_IRQ-1:0]    irq_ack,
    output logic                interruption,
    output logic                ie,
    output logic                carry,
    output logic                zero
);

    localparam int unsigned ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTER   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [N_IRQ-1:0]    irq_q;
    logic [N_IRQ-1:0]    pending;
    logic [N_IRQ-1:0]    pending_next;
    logic [N_IRQ-1:0]    rise;
    logic [N_IRQ-1:0]    clr;
    logic [ID_W-1:0]     id;
    logic [ID_W-1:0]     id_next;
    logic [ID_W-1:0]     sel;

    logic                ie_next;
    logic [PC_WIDTH-1:0] ret_pc_next;
    logic [PC_WIDTH-1:0] vector_next;
    logic [N_IRQ-1:0]    irq_ack_next;
    logic                take_next;
    logic                interruption_next;

    logic                main_c;
    logic                main_z;
    logic                main_c_next;
    logic                main_z_next;
`ifdef INTR_FLAG_BANK_EN
    logic                int_c;
    logic                int_z;
    logic                int_c_next;
    logic                int_z_next;
`endif
    logic                carry_next;
    logic                zero_next;

    // Edge detection: a new edge is folded into pending one cycle later.
    assign rise = irq & ~irq_q;

    // Lowest pending index wins.
    always_comb begin
        sel = '0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel = ID_W'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, enable, served-id and return-address logic.
    always_comb begin
        state_next  = state;
        id_next     = id;
        ie_next     = ie;
        ret_pc_next = ret_pc;
        clr         = '0;
        case (state)
            IDLE: begin
                if (di) begin
                    ie_next = 1'b0;
                end else if (ei) begin
                    ie_next = 1'b1;
                end
                if (ie && !di && (|pending)) begin
                    state_next = ENTER;
                    id_next    = sel;
                end
            end
            ENTER: begin
                state_next  = SERVICE;
                ie_next     = 1'b0;
                ret_pc_next = pc_now;
                clr         = N_IRQ'(1) << id;
            end
            SERVICE: begin
                if (reti) begin
                    state_next = IDLE;
                    ie_next    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A same-cycle set overrides the clear of the served line.
    assign pending_next = (pending & ~clr) | rise;

    // Outputs are registered from the next-cycle view of state and id.
    always_comb begin
        take_next         = (state_next == ENTER);
        interruption_next = (state_next == SERVICE);
        irq_ack_next      = take_next ? (N_IRQ'(1) << id_next) : '0;
        vector_next       = VEC_BASE + (PC_WIDTH'(id_next) << 2);
    end

    // Flag banks; ENTER never writes them because the instruction is annulled.
`ifdef INTR_FLAG_BANK_EN
    always_comb begin
        main_c_next = main_c;
        main_z_next = main_z;
        int_c_next  = int_c;
        int_z_next  = int_z;
        if (state == IDLE && flag_we) begin
            main_c_next = alu_carry;
            main_z_next = alu_zero;
        end
        if (state == ENTER) begin
            int_c_next = 1'b0;
            int_z_next = 1'b0;
        end else if (state == SERVICE && flag_we) begin
            int_c_next = alu_carry;
            int_z_next = alu_zero;
        end
        carry_next = interruption_next ? int_c_next : main_c_next;
        zero_next  = interruption_next ? int_z_next : main_z_next;
    end
`else
    always_comb begin
        main_c_next = main_c;
        main_z_next = main_z;
        if ((state == IDLE || state == SERVICE) && flag_we) begin
            main_c_next = alu_carry;
            main_z_next = alu_zero;
        end
        carry_next = main_c_next;
        zero_next  = main_z_next;
    end
`endif

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q        <= '0;
            pending      <= '0;
            id           <= '0;
            ie           <= 1'b0;
            ret_pc       <= '0;
            main_c       <= 1'b0;
            main_z       <= 1'b0;
`ifdef INTR_FLAG_BANK_EN
            int_c        <= 1'b0;
            int_z        <= 1'b0;
`endif
            take         <= 1'b0;
            vector       <= VEC_BASE;
            irq_ack      <= '0;
            interruption <= 1'b0;
            carry        <= 1'b0;
            zero         <= 1'b0;
        end else begin
            irq_q        <= irq;
            pending      <= pending_next;
            id           <= id_next;
            ie           <= ie_next;
            ret_pc       <= ret_pc_next;
            main_c       <= main_c_next;
            main_z       <= main_z_next;
`ifdef INTR_FLAG_BANK_EN
            int_c        <= int_c_next;
            int_z        <= int_z_next;
`endif
            take         <= take_next;
            vector       <= vector_next;
            irq_ack      <= irq_ack_next;
            interruption <= interruption_next;
            carry        <= carry_next;
            zero         <= zero_next;
        end
    end

endmodule
